dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have ports req_valid, input, 1, access request (held until done); req_we, input, 1, 1 = store; req_size, input, 2, 0 = byte, 1 = half, 2 = word; req_addr, input, 32; req_wdata, input, 32.
REQ-004 SHALL have ports done, output, 1, one-cycle completion pulse; rdata, output, 32, load data with bytes little-endian from bit 0 and upper bytes zero for byte/half; busy, output, 1, not IDLE.
REQ-005 SHALL have ports c_addr, output, 32; c_data, input, 32; c_hit, input, 1; c_replace, output, 1; c_data_r, output, 32; c_valid_r, output, 1. These are the cache lookup and replace port.
REQ-006 SHALL have ports mem_req, output, 1; mem_grant, input, 1; mem_we, output, 1; mem_addr, output, 32; mem_wdata, output, 8; mem_rdata, input, 8. This is the byte-wide shared memory port.

Function
REQ-007 SHALL implement states IDLE, FILL, STORE, DONE.
REQ-008 SHALL accept a request only in IDLE with req_valid=1, and SHALL latch we/size/addr/wdata at acceptance.
REQ-009 SHALL force the latched address to natural alignment: half clears bit 0, word clears bits 1:0.
REQ-010 SHALL treat addr[17:16]==2'b11 as uncacheable I/O: no cache replace, and no cache data is used.
REQ-011 SHALL drive c_addr from req_addr in IDLE and from the latched address otherwise.
REQ-012 On a cacheable load with c_hit=1 in IDLE, SHALL go to DONE with rdata taken from c_data (shifted/masked per size) -> done asserted 1 cycle after acceptance.
REQ-013 On a cacheable load miss, SHALL go to FILL and read the 4 bytes of the aligned word in order at offsets +0..+3. For I/O loads, SHALL read only size-many bytes starting at the exact address.
REQ-014 Memory timing: SHALL hold mem_req=1 with a valid mem_addr; a byte transfers in a cycle where mem_req&mem_grant=1; read data appears on mem_rdata the following cycle. SHALL issue the next byte only after a grant and SHALL stall without advancing while mem_grant=0.
REQ-015 On FILL completion of a cacheable word, SHALL pulse c_replace=1 with c_valid_r=1 and c_data_r = the assembled word for exactly 1 cycle, entering DONE in that same cycle.
REQ-016 A store SHALL enter STORE and write size-many bytes of req_wdata low-first with mem_we=1 (write-through, no allocate on miss).
REQ-017 For a cacheable store where c_hit=1 at acceptance, SHALL pulse c_replace on STORE completion, with c_data_r = c_data merged with the stored bytes at their lane offsets.
REQ-018 In DONE, SHALL assert done=1 for 1 cycle, then return to IDLE; rdata SHALL hold until the next load completes.
REQ-019 SHALL keep mem_req=0 in IDLE and DONE, and c_replace=0 except as stated in REQ-015 and REQ-017.
REQ-020 SHALL ignore req_valid outside IDLE, and SHALL not accept a request in the DONE cycle.

Reset
REQ-021 On rst=1 at any time, including mid-FILL/STORE, SHALL immediately enter IDLE and drive done=0, busy=0, mem_req=0, mem_we=0, c_replace=0, c_valid_r=0, rdata=0, with the byte counter cleared; any partial transfer is discarded and no replace is issued.

Configuration
REQ-022 With DCACHE_CTRL_CACHE_EN defined, SHALL behave as above.
REQ-023 Without DCACHE_CTRL_CACHE_EN, SHALL treat every access as uncacheable and SHALL hold c_replace=0. Every load SHALL read size-many bytes from memory, and c_hit SHALL be ignored.

Verification
REQ-024 Cacheable word load, c_hit=1, c_data=0x11223344 -> done 1 cycle after accept, rdata=0x11223344, mem_req never asserted.
REQ-025 Word load 0x00001000 miss, mem_grant=1 always, bytes 0xEF,0xBE,0xAD,0xDE -> 4 reads at 0x1000..0x1003, one c_replace with c_data_r=0xDEADBEEF, rdata=0xDEADBEEF.
REQ-026 Byte store 0x5A to 0x00002003, hit, c_data=0x00000000 -> one mem write to 0x2003 with data 0x5A, c_replace with c_data_r=0x5A000000.
REQ-027 Half load from I/O 0x00030000 -> exactly 2 reads, c_replace never asserted; mem_grant=0 for 3 cycles mid-transfer -> mem_addr held, no byte skipped.
REQ-028 rst pulsed after 2nd byte of a fill -> outputs at reset values, no c_replace; next request is serviced correctly.
REQ-029 Build without DCACHE_CTRL_CACHE_EN: word load with c_hit=1 -> 4 memory reads, c_replace=0.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Data-cache access controller: serves loads/stores via a cache lookup/replace port and a byte-wide memory port.
// Optional feature macro: DCACHE_CTRL_CACHE_EN (undefined = every access is uncacheable, no replaces).
module dcache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] c_addr,
  input  logic [31:0] c_data,
  input  logic        c_hit,
  output logic        c_replace,
  output logic [31:0] c_data_r,
  output logic        c_valid_r,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, FILL, STORE, DONE} state_t;
  state_t state, state_nx;

  logic        we_q, cache_q, hit_q, pend_q;
  logic [1:0]  size_q, pidx_q, lane;
  logic [2:0]  icnt_q, xfer_n;
  logic [31:0] addr_q, wdata_q, buf_q, word_now, merged, base, req_aligned;
  logic        req_cache, fill_last, store_last;

  function automatic logic [31:0] align(input logic [31:0] a, input logic [1:0] s);
    case (s)
      2'd0:    return a;
      2'd1:    return {a[31:1], 1'b0};
      default: return {a[31:2], 2'b00};
    endcase
  endfunction

  function automatic logic [2:0] nbytes(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] ln,
                                          input logic [1:0] s);
    logic [31:0] sh;
    sh = w >> {ln, 3'b000};
    case (s)
      2'd0:    return {24'd0, sh[7:0]};
      2'd1:    return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign req_aligned = align(req_addr, req_size);
`ifdef DCACHE_CTRL_CACHE_EN
  assign req_cache = (req_addr[17:16] != 2'b11);
`else
  assign req_cache = 1'b0;
`endif

  // Cacheable load misses fill the whole aligned word; everything else moves size-many bytes.
  assign xfer_n = (cache_q && !we_q) ? 3'd4 : nbytes(size_q);
  assign base   = (cache_q && !we_q) ? {addr_q[31:2], 2'b00} : addr_q;

  assign fill_last  = (state == FILL) && pend_q && ({1'b0, pidx_q} == xfer_n - 3'd1);
  assign store_last = (state == STORE) && mem_grant && (icnt_q == xfer_n - 3'd1);

  always_comb begin
    word_now = buf_q;
    if (pend_q) word_now[{pidx_q, 3'b000} +: 8] = mem_rdata;
  end

  always_comb begin
    merged = c_data;
    lane   = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < xfer_n) begin
        lane = addr_q[1:0] + 2'(k);
        merged[{lane, 3'b000} +: 8] = wdata_q[8*k +: 8];
      end
    end
  end

  assign c_addr    = (state == IDLE) ? req_addr : addr_q;
  assign mem_addr  = base + {29'd0, icnt_q};
  assign mem_wdata = wdata_q[{icnt_q[1:0], 3'b000} +: 8];
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign c_valid_r = c_replace;

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    c_replace = 1'b0;
    c_data_r  = 32'd0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_we)                 state_nx = STORE;
          else if (req_cache && c_hit) state_nx = DONE;
          else                        state_nx = FILL;
        end
      end
      FILL: begin
        mem_req = (icnt_q < xfer_n);
        if (fill_last) begin
          state_nx  = DONE;
          c_replace = cache_q;
          c_data_r  = word_now;
        end
      end
      STORE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (store_last) begin
          state_nx  = DONE;
          c_replace = cache_q && hit_q;
          c_data_r  = merged;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      cache_q <= 1'b0;
      hit_q   <= 1'b0;
      pend_q  <= 1'b0;
      size_q  <= 2'd0;
      pidx_q  <= 2'd0;
      icnt_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      buf_q   <= 32'd0;
      rdata   <= 32'd0;
    end else begin
      state  <= state_nx;
      pend_q <= (state == FILL) && mem_req && mem_grant;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_aligned;
        wdata_q <= req_wdata;
        cache_q <= req_cache;
        hit_q   <= c_hit;
        icnt_q  <= 3'd0;
        buf_q   <= 32'd0;
        if (!req_we && req_cache && c_hit)
          rdata <= extract(c_data, req_aligned[1:0], req_size);
      end
      if ((state == FILL || state == STORE) && mem_req && mem_grant) begin
        icnt_q <= icnt_q + 3'd1;
        pidx_q <= icnt_q[1:0];
      end
      if (state == FILL && pend_q) buf_q <= word_now;
      // I/O loads collect bytes from lane 0 upward, so only fills pick a lane.
      if (fill_last)
        rdata <= extract(word_now, cache_q ? addr_q[1:0] : 2'b00, size_q);
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl; expectations follow whether DCACHE_CTRL_CACHE_EN is defined.
module tb_dcache_ctrl;
`ifdef DCACHE_CTRL_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        done, busy, c_replace, c_valid_r, mem_req, mem_we;
  logic [31:0] rdata, c_addr, c_data_r, mem_addr;
  logic [31:0] c_data = 32'd0;
  logic        c_hit = 1'b0, mem_grant = 1'b1;
  logic [7:0]  mem_wdata, mem_rdata = 8'd0;

  int checks = 0, errors = 0, last_cycles = 0;
  int nreads = 0, nwrites = 0, nrepl = 0;
  logic [31:0] rd_addr [8];
  logic [31:0] wr_addr [8];
  logic [7:0]  wr_data [8];
  logic [31:0] repl_data = 32'd0;
  logic        repl_valid = 1'b0;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata), .busy(busy),
    .c_addr(c_addr), .c_data(c_data), .c_hit(c_hit), .c_replace(c_replace),
    .c_data_r(c_data_r), .c_valid_r(c_valid_r), .mem_req(mem_req), .mem_grant(mem_grant),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h1000: return 8'hEF;
      32'h1001: return 8'hBE;
      32'h1002: return 8'hAD;
      32'h1003: return 8'hDE;
      default:  return a[7:0] ^ 8'h5C;
    endcase
  endfunction

  // Memory and cache-port monitor: logs every granted transfer and replace, returns read data next cycle.
  always @(posedge clk) begin
    logic [31:0] a;
    if (c_replace) begin
      nrepl++;
      repl_data  = c_data_r;
      repl_valid = c_valid_r;
    end
    if (mem_req && mem_grant) begin
      a = mem_addr;
      if (mem_we) begin
        if (nwrites < 8) begin
          wr_addr[nwrites] = a;
          wr_data[nwrites] = mem_wdata;
        end
        nwrites++;
      end else begin
        if (nreads < 8) rd_addr[nreads] = a;
        nreads++;
        #1 mem_rdata = mem_byte(a);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    nreads = 0; nwrites = 0; nrepl = 0;
    repl_data = 32'd0; repl_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic hit, input logic [31:0] cdata);
    bit seen;
    clear_log();
    @(negedge clk);
    req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    c_hit = hit; c_data = cdata; req_valid = 1'b1;
    seen = 1'b0;
    last_cycles = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      last_cycles++;
      if (done) begin
        seen = 1'b1;
        req_valid = 1'b0;
      end
    end
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    @(negedge clk) rst = 1'b0;

    // word load with a hit: served from the cache when caching is built in, from memory otherwise
    applyStimulus(1'b0, 2'd2, 32'h0000_1000, 32'd0, 1'b1, 32'h1122_3344);
    checkOutput("hit_latency", last_cycles, CACHE ? 32'd1 : 32'd6);
    checkOutput("hit_nreads", nreads, CACHE ? 32'd0 : 32'd4);
    checkOutput("hit_rdata", rdata, CACHE ? 32'h1122_3344 : 32'hDEAD_BEEF);
    checkOutput("hit_nrepl", nrepl, 32'd0);

    applyStimulus(1'b0, 2'd2, 32'h0000_1000, 32'd0, 1'b0, 32'h0);
    checkOutput("miss_nreads", nreads, 32'd4);
    checkOutput("miss_addr0", rd_addr[0], 32'h1000);
    checkOutput("miss_addr3", rd_addr[3], 32'h1003);
    checkOutput("miss_nrepl", nrepl, CACHE ? 32'd1 : 32'd0);
    checkOutput("miss_repl_data", repl_data, CACHE ? 32'hDEAD_BEEF : 32'd0);
    checkOutput("miss_repl_valid", {31'd0, repl_valid}, CACHE ? 32'd1 : 32'd0);
    checkOutput("miss_rdata", rdata, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 2'd0, 32'h0000_2003, 32'h0000_005A, 1'b1, 32'h0);
    checkOutput("sb_nwrites", nwrites, 32'd1);
    checkOutput("sb_waddr", wr_addr[0], 32'h2003);
    checkOutput("sb_wdata", {24'd0, wr_data[0]}, 32'h5A);
    checkOutput("sb_nrepl", nrepl, CACHE ? 32'd1 : 32'd0);
    checkOutput("sb_repl_data", repl_data, CACHE ? 32'h5A00_0000 : 32'd0);
    checkOutput("sb_rdata_hold", rdata, 32'hDEAD_BEEF);

    // I/O half load with a 3-cycle grant stall after the first byte
    fork
      applyStimulus(1'b0, 2'd1, 32'h0003_0000, 32'd0, 1'b1, 32'hFFFF_FFFF);
      begin
        for (int i = 0; i < 50 && nreads < 1; i++) begin
          @(posedge clk); #1;
        end
        checkOutput("io_first_grant", nreads, 32'd1);
        mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          checkOutput("io_stall_addr", mem_addr, 32'h0003_0001);
          checkOutput("io_stall_nreads", nreads, 32'd1);
        end
        mem_grant = 1'b1;
      end
    join
    checkOutput("io_nreads", nreads, 32'd2);
    checkOutput("io_addr1", rd_addr[1], 32'h0003_0001);
    checkOutput("io_nrepl", nrepl, 32'd0);
    checkOutput("io_rdata", rdata, 32'h0000_5D5C);

    applyStimulus(1'b0, 2'd0, 32'h0000_1002, 32'd0, 1'b0, 32'h0);
    checkOutput("lb_nreads", nreads, CACHE ? 32'd4 : 32'd1);
    checkOutput("lb_addr0", rd_addr[0], CACHE ? 32'h1000 : 32'h1002);
    checkOutput("lb_rdata", rdata, 32'h0000_00AD);

    applyStimulus(1'b1, 2'd1, 32'h0000_2001, 32'h1234_CAFE, 1'b1, 32'h1122_3344);
    checkOutput("sh_nwrites", nwrites, 32'd2);
    checkOutput("sh_waddr0", wr_addr[0], 32'h2000);
    checkOutput("sh_wdata0", {24'd0, wr_data[0]}, 32'hFE);
    checkOutput("sh_wdata1", {24'd0, wr_data[1]}, 32'hCA);
    checkOutput("sh_repl_data", repl_data, CACHE ? 32'h1122_CAFE : 32'd0);

    // reset in the middle of a fill
    clear_log();
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_1000; c_hit = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 50 && nreads < 2; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("rf_two_reads", nreads, 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("rf_done", {31'd0, done}, 32'd0);
    checkOutput("rf_busy", {31'd0, busy}, 32'd0);
    checkOutput("rf_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rf_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rf_c_replace", {31'd0, c_replace}, 32'd0);
    checkOutput("rf_c_valid_r", {31'd0, c_valid_r}, 32'd0);
    checkOutput("rf_rdata", rdata, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rf_no_repl", nrepl, 32'd0);
    checkOutput("rf_idle", {31'd0, busy}, 32'd0);

    applyStimulus(1'b0, 2'd2, 32'h0000_1000, 32'd0, 1'b0, 32'h0);
    checkOutput("rf_after_nreads", nreads, 32'd4);
    checkOutput("rf_after_rdata", rdata, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
